cpu_run_ctrl: RTL and testbench

Parametrised run controller that replaces the fixed-duration reset/finish sequencing around the ARM CPU, IC and Data_Memory. It holds the core in reset for a configurable number of cycles and counts execution cycles. It ends a run on whichever comes first: a halt PC, a PC stall, a pass/fail write to a memory-mapped "tohost" word, or a cycle timeout. It is synthesizable and sits beside the core, snooping its PC and data-memory write port.

---
 rtl/cpu_run_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller for the CPU core: holds reset, counts RUN cycles and ends the run on
// the tohost store (CPU_RUN_CTRL_MMIO_EN only), halt PC, PC stall or timeout.
module cpu_run_ctrl #(
  parameter int                ADDR_W       = 64,
  parameter int                DATA_W       = 64,
  parameter int                CNT_W        = 32,
  parameter int                RESET_CYCLES = 2,
  parameter int                MAX_CYCLES   = 1000,
  parameter logic [ADDR_W-1:0] HALT_PC      = '1,
  parameter int                STALL_LIMIT  = 4,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 'h1000
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              control_memwrite,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic [1:0]        status,
  output logic [DATA_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RESETTING = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  localparam int RC_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam int ST_W = $clog2(STALL_LIMIT + 1);

  logic [1:0]        state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [1:0]        status_q, status_d;
  logic [ST_W-1:0]   stall_q, stall_d;
  logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;
  logic              first_q, first_d;
  logic              launch, pc_same, halt_hit, timeout_hit, mmio_hit;

`ifdef CPU_RUN_CTRL_MMIO_EN
  logic [DATA_W-1:0] exit_q, exit_d;
  assign mmio_hit = control_memwrite && (mem_address == TOHOST_ADDR);
`else
  logic unused_mmio;
  assign unused_mmio = ^{mem_address, mem_data_in, control_memwrite};
  assign mmio_hit    = 1'b0;
`endif

  // first_q masks the stale previous PC left over from an earlier run
  assign pc_same     = !first_q && (pc == prev_pc_q);
  assign halt_hit    = (pc == HALT_PC) || (pc_same && (stall_q == ST_W'(STALL_LIMIT - 2)));
  assign timeout_hit = (cyc_q == CNT_W'(MAX_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cyc_d     = cyc_q;
    status_d  = status_q;
    stall_d   = stall_q;
    prev_pc_d = prev_pc_q;
    first_d   = first_q;
    launch    = 1'b0;
`ifdef CPU_RUN_CTRL_MMIO_EN
    exit_d    = exit_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: launch = start;
      S_RESETTING: begin
        if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
          state_d = S_RUN;
          first_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      S_RUN: begin
        cyc_d     = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
        prev_pc_d = pc;
        first_d   = 1'b0;
        stall_d   = pc_same ? stall_q + ST_W'(1) : '0;
        if (mmio_hit) begin
          state_d = S_DONE;
`ifdef CPU_RUN_CTRL_MMIO_EN
          status_d = (mem_data_in == '0) ? 2'b01 : 2'b10;
          exit_d   = (mem_data_in == '0) ? '0 : mem_data_in;
`endif
        end else if (halt_hit) begin
          state_d  = S_DONE;
          status_d = 2'b01;
        end else if (timeout_hit) begin
          state_d  = S_DONE;
          status_d = 2'b11;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      state_d   = S_RESETTING;
      rst_cnt_d = '0;
      cyc_d     = '0;
      status_d  = 2'b00;
      stall_d   = '0;
`ifdef CPU_RUN_CTRL_MMIO_EN
      exit_d    = '0;
`endif
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      cyc_q     <= '0;
      status_q  <= 2'b00;
      stall_q   <= '0;
      prev_pc_q <= '0;
      first_q   <= 1'b1;
`ifdef CPU_RUN_CTRL_MMIO_EN
      exit_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cyc_q     <= cyc_d;
      status_q  <= status_d;
      stall_q   <= stall_d;
      prev_pc_q <= prev_pc_d;
      first_q   <= first_d;
`ifdef CPU_RUN_CTRL_MMIO_EN
      exit_q    <= exit_d;
`endif
    end
  end

  assign core_reset  = (state_q != S_RUN);
  assign running     = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign status      = status_q;
  assign cycle_count = cyc_q;
`ifdef CPU_RUN_CTRL_MMIO_EN
  assign exit_code   = exit_q;
`else
  assign exit_code   = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with RESET_CYCLES=2, MAX_CYCLES=10, STALL_LIMIT=4.
module tb_cpu_run_ctrl;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic [63:0] pc = '0;
  logic [63:0] mem_address = '0;
  logic [63:0] mem_data_in = '0;
  logic        control_memwrite = 1'b0;
  logic        core_reset, running, done;
  logic [1:0]  status;
  logic [63:0] exit_code;
  logic [31:0] cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  cpu_run_ctrl #(
    .RESET_CYCLES(2),
    .MAX_CYCLES(10),
    .STALL_LIMIT(4)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .start(start), .pc(pc),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .control_memwrite(control_memwrite), .core_reset(core_reset),
    .running(running), .done(done), .status(status),
    .exit_code(exit_code), .cycle_count(cycle_count)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // start pulse, then two RESETTING cycles before the core runs
  task automatic run_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_rs0_core_reset"}, 64'(core_reset), 64'd1);
    chk({tag, "_rs0_running"}, 64'(running), 64'd0);
    chk({tag, "_rs0_status"}, 64'(status), 64'd0);
    chk({tag, "_rs0_cycles"}, 64'(cycle_count), 64'd0);
    tick();
    chk({tag, "_rs1_core_reset"}, 64'(core_reset), 64'd1);
    tick();
    chk({tag, "_run_core_reset"}, 64'(core_reset), 64'd0);
    chk({tag, "_run_running"}, 64'(running), 64'd1);
  endtask

  task automatic timeout_run(input string tag);
    for (int k = 1; k <= 10; k++) begin
      pc = 64'(k * 4);
      tick();
      chk({tag, "_cnt"}, 64'(cycle_count), 64'(k));
      chk({tag, "_done"}, 64'(done), 64'(k == 10));
    end
    chk({tag, "_status"}, 64'(status), 64'd3);
    chk({tag, "_core_reset"}, 64'(core_reset), 64'd1);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_exit", exit_code, 64'd0);
    chk("rst_cycles", 64'(cycle_count), 64'd0);
    RESET = 1'b0;
    tick();
    chk("idle_core_reset", 64'(core_reset), 64'd1);

    // timeout, with a start pulse during RUN that must be ignored
    run_start("to");
    for (int k = 1; k <= 10; k++) begin
      pc = 64'(k * 4);
      start = (k == 2);
      tick();
      chk("to_cnt", 64'(cycle_count), 64'(k));
      chk("to_done", 64'(done), 64'(k == 10));
    end
    start = 1'b0;
    chk("to_status", 64'(status), 64'd3);
    chk("to_core_reset", 64'(core_reset), 64'd1);
    pc = 64'h999;
    tick();
    tick();
    chk("frz_cnt", 64'(cycle_count), 64'd10);
    chk("frz_status", 64'(status), 64'd3);
    chk("frz_done", 64'(done), 64'd1);

    // stall: pc sticks at 0x40 from RUN cycle 3, halt on 4th equal sample
    run_start("st");
    for (int k = 1; k <= 6; k++) begin
      pc = (k == 1) ? 64'h100 : (k == 2) ? 64'h104 : 64'h40;
      tick();
      chk("st_done", 64'(done), 64'(k == 6));
    end
    chk("st_status", 64'(status), 64'd1);
    chk("st_cnt", 64'(cycle_count), 64'd6);

    // stale previous pc (0x40) must not shorten the stall window
    run_start("sp");
    for (int k = 1; k <= 4; k++) begin
      pc = 64'h40;
      tick();
      chk("sp_done", 64'(done), 64'(k == 4));
    end
    chk("sp_status", 64'(status), 64'd1);
    chk("sp_cnt", 64'(cycle_count), 64'd4);

    // tohost store and halt pc in the same cycle
    run_start("pr");
    for (int k = 1; k <= 5; k++) begin
      pc = (k == 5) ? '1 : 64'(k * 4);
      control_memwrite = (k == 5);
      mem_address = 64'h1000;
      mem_data_in = 64'h2A;
      tick();
      chk("pr_done", 64'(done), 64'(k == 5));
    end
    control_memwrite = 1'b0;
    chk("pr_cnt", 64'(cycle_count), 64'd5);
`ifdef CPU_RUN_CTRL_MMIO_EN
    chk("pr_status", 64'(status), 64'd2);
    chk("pr_exit", exit_code, 64'h2A);
`else
    chk("pr_status", 64'(status), 64'd1);
    chk("pr_exit", exit_code, 64'd0);
`endif

    // store of 1 to tohost on RUN cycle 3
    run_start("sv");
    begin
      int stop;
`ifdef CPU_RUN_CTRL_MMIO_EN
      stop = 3;
`else
      stop = 10;
`endif
      for (int k = 1; k <= stop; k++) begin
        pc = 64'h200 + 64'(k * 4);
        control_memwrite = (k == 3);
        mem_address = 64'h1000;
        mem_data_in = 64'h1;
        tick();
        chk("sv_done", 64'(done), 64'(k == stop));
      end
      control_memwrite = 1'b0;
      chk("sv_cnt", 64'(cycle_count), 64'(stop));
    end
`ifdef CPU_RUN_CTRL_MMIO_EN
    chk("sv_status", 64'(status), 64'd2);
    chk("sv_exit", exit_code, 64'h1);
`else
    chk("sv_status", 64'(status), 64'd3);
    chk("sv_exit", exit_code, 64'd0);
`endif

    // RESET from DONE clears the latched result
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rd_done", 64'(done), 64'd0);
    chk("rd_status", 64'(status), 64'd0);
    chk("rd_cnt", 64'(cycle_count), 64'd0);

    // RESET in RUN cycle 4
    run_start("rm");
    for (int k = 1; k <= 3; k++) begin
      pc = 64'(k * 4);
      tick();
    end
    chk("rm_cnt_pre", 64'(cycle_count), 64'd3);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rm_core_reset", 64'(core_reset), 64'd1);
    chk("rm_running", 64'(running), 64'd0);
    chk("rm_cnt", 64'(cycle_count), 64'd0);

    // RESET wins over a simultaneous start
    RESET = 1'b1;
    start = 1'b1;
    tick();
    RESET = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rws_running", 64'(running), 64'd0);
    end

    // clean repeat run with identical timing
    run_start("rp");
    timeout_run("rp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
